// File: rtl/game_pkg.sv
// Shared types and parameter defaults for the runner-game controller.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_OVER
  } game_st_e;

  typedef enum logic [1:0] {
    J_GROUND,
    J_ASCEND,
    J_DESCEND
  } jump_st_e;

  typedef logic [3:0] bcd_t;

  localparam int TICK_DIV_DEF  = 250000;
  localparam int JUMP_STEP_DEF = 2;
  localparam int JUMP_MAX_DEF  = 40;
  localparam int SCORE_DIV_DEF = 8;

endpackage

// File: rtl/bcd_counter.sv
// Four-digit BCD incrementer, saturating at 9999.
// Clear has priority over enable.
module bcd_counter
  import game_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        clr_i,
  input  logic        en_i,
  output logic [15:0] count_o
);

  bcd_t [3:0] d_q, d_d;

  always_comb begin
    logic carry;
    d_d   = d_q;
    carry = 1'b0;
    if (clr_i) begin
      d_d = '0;
    end else if (en_i && d_q != 16'h9999) begin
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (d_q[i] == 4'd9) begin
            d_d[i] = 4'd0;
          end else begin
            d_d[i] = d_q[i] + 4'd1;
            carry  = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) d_q <= '0;
    else        d_q <= d_d;
  end

  assign count_o = d_q;

endmodule

// File: rtl/game_ctrl.sv
// Runner-game controller: game FSM, frame divider, jump FSM, BCD score.
// Define GAME_CTRL_HIGH_SCORE_EN to add the high_score output.
module game_ctrl
  import game_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int JUMP_STEP = JUMP_STEP_DEF,
  parameter int JUMP_MAX  = JUMP_MAX_DEF,
  parameter int SCORE_DIV = SCORE_DIV_DEF
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        button_start,
  input  logic        button_jump,
  input  logic        obstacle_near,
  input  logic [5:0]  obstacle_height,
  output logic        game_status,
  output logic        game_over,
  output logic        frame_tick,
  output logic [5:0]  dinosaur_height,
  output logic [15:0] score
`ifdef GAME_CTRL_HIGH_SCORE_EN
  ,
  output logic [15:0] high_score
`endif
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCORE_LAST = SW'(SCORE_DIV - 1);
  localparam logic [6:0]    STEP7 = 7'(JUMP_STEP);
  localparam logic [6:0]    MAX7  = 7'(JUMP_MAX);
  localparam logic [5:0]    MAX6  = 6'(JUMP_MAX);

  game_st_e        st_q, st_d;
  jump_st_e        js_q, js_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   sdiv_q, sdiv_d;
  logic [5:0]      h_q, h_d;
  logic            pend_q, pend_d;
  logic            start_q, jump_q;

  logic start_edge, jump_edge;
  logic tick, hit, adv, enter, score_inc;
  logic [6:0] h7, up7;
  logic [5:0] h_up, h_dn;

  assign start_edge = button_start & ~start_q;
  assign jump_edge  = button_jump & ~jump_q;
  assign tick  = (st_q == ST_RUN) && (cnt_q == TICK_LAST);
  // Collision uses the height before this tick's update.
  assign hit   = tick && obstacle_near && (h_q < obstacle_height);
  assign adv   = tick && !hit;
  assign enter = (st_q != ST_RUN) && start_edge;
  assign score_inc = adv && (sdiv_q == SCORE_LAST);

  assign h7   = {1'b0, h_q};
  assign up7  = h7 + STEP7;
  assign h_up = (up7 >= MAX7) ? MAX6 : up7[5:0];
  assign h_dn = (h7 > STEP7) ? 6'(h7 - STEP7) : 6'd0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st_q    <= ST_IDLE;
      js_q    <= J_GROUND;
      cnt_q   <= '0;
      sdiv_q  <= '0;
      h_q     <= '0;
      pend_q  <= 1'b0;
      start_q <= 1'b0;
      jump_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      js_q    <= js_d;
      cnt_q   <= cnt_d;
      sdiv_q  <= sdiv_d;
      h_q     <= h_d;
      pend_q  <= pend_d;
      start_q <= button_start;
      jump_q  <= button_jump;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_IDLE: if (start_edge) st_d = ST_RUN;
      ST_RUN:  if (hit) st_d = ST_OVER;
      ST_OVER: if (start_edge) st_d = ST_RUN;
      default: st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    js_d   = js_q;
    h_d    = h_q;
    pend_d = pend_q;
    cnt_d  = '0;
    sdiv_d = sdiv_q;
    if (enter) begin
      js_d   = J_GROUND;
      h_d    = '0;
      pend_d = 1'b0;
      sdiv_d = '0;
    end else if (st_q == ST_RUN) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
      if (adv) begin
        sdiv_d = (sdiv_q == SCORE_LAST) ? '0 : sdiv_q + SW'(1);
        unique case (js_q)
          J_GROUND: begin
            if (pend_q) begin
              h_d    = h_up;
              pend_d = 1'b0;
              js_d   = (h_up == MAX6) ? J_DESCEND : J_ASCEND;
            end
          end
          J_ASCEND: begin
            h_d = h_up;
            if (h_up == MAX6) js_d = J_DESCEND;
          end
          J_DESCEND: begin
            h_d = h_dn;
            if (h_dn == 6'd0) js_d = J_GROUND;
          end
          default: js_d = J_GROUND;
        endcase
      end
      // Only a jump that stays grounded this cycle can arm; airborne edges drop.
      if (jump_edge && js_q == J_GROUND && js_d == J_GROUND)
        pend_d = 1'b1;
    end
  end

  always_comb begin
    game_status = (st_q == ST_RUN);
    game_over   = (st_q == ST_OVER);
    frame_tick  = tick;
  end

  assign dinosaur_height = h_q;

  bcd_counter u_score (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .clr_i   (enter),
    .en_i    (score_inc),
    .count_o (score)
  );

`ifdef GAME_CTRL_HIGH_SCORE_EN
  logic [15:0] hs_q;

  // BCD ordering matches numeric ordering, so a plain compare works.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                      hs_q <= '0;
    else if (hit && score > hs_q)    hs_q <= score;
  end

  assign high_score = hs_q;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl with a trajectory/score reference model.
module tb_game_ctrl;

  localparam int TD = 4;
  localparam int JS = 2;
  localparam int JM = 6;
  localparam int SD = 2;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        button_start, button_jump, obstacle_near;
  logic [5:0]  obstacle_height;
  logic        game_status, game_over, frame_tick;
  logic [5:0]  dinosaur_height;
  logic [15:0] score;
`ifdef GAME_CTRL_HIGH_SCORE_EN
  logic [15:0] high_score;
`endif
  logic        b_clr, b_en;
  logic [15:0] b_cnt;

  always #5 CLK = ~CLK;

  game_ctrl #(
    .TICK_DIV (TD),
    .JUMP_STEP(JS),
    .JUMP_MAX (JM),
    .SCORE_DIV(SD)
  ) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .button_start   (button_start),
    .button_jump    (button_jump),
    .obstacle_near  (obstacle_near),
    .obstacle_height(obstacle_height),
    .game_status    (game_status),
    .game_over      (game_over),
    .frame_tick     (frame_tick),
    .dinosaur_height(dinosaur_height),
    .score          (score)
`ifdef GAME_CTRL_HIGH_SCORE_EN
    ,
    .high_score     (high_score)
`endif
  );

  bcd_counter u_bcd (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .clr_i  (b_clr),
    .en_i   (b_en),
    .count_o(b_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Model: 0 idle, 1 running, 2 over; height follows a precomputed arc.
  int m_st, m_n, m_ticks, m_k, m_h, m_hs;
  bit m_air, m_pend, m_ps, m_pj;
  int traj[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  function automatic int score_int();
    return (m_ticks / SD > 9999) ? 9999 : m_ticks / SD;
  endfunction

  function automatic void build_traj();
    int h = 0;
    traj.delete();
    do begin
      h = (h + JS >= JM) ? JM : h + JS;
      traj.push_back(h);
    end while (h != JM);
    do begin
      h = (h - JS <= 0) ? 0 : h - JS;
      traj.push_back(h);
    end while (h != 0);
  endfunction

  function automatic void model_reset();
    m_st = 0; m_n = 0; m_ticks = 0; m_k = 0; m_h = 0; m_hs = 0;
    m_air = 0; m_pend = 0; m_ps = 0; m_pj = 0;
  endfunction

  function automatic void model_step(bit s, bit j, bit near, int oh);
    bit se = s && !m_ps;
    bit je = j && !m_pj;
    bit tk = (m_st == 1) && (m_n % TD == TD - 1);
    bit air0 = m_air;
    if (m_st != 1) begin
      if (se) begin
        m_st = 1; m_n = 0; m_ticks = 0; m_k = 0;
        m_h = 0; m_air = 0; m_pend = 0;
      end
    end else begin
      m_n++;
      if (tk) begin
        if (near && m_h < oh) begin
          if (score_int() > m_hs) m_hs = score_int();
          m_st = 2;
        end else begin
          m_ticks++;
          if (m_air) begin
            m_k++;
            m_h = traj[m_k];
            if (m_k == traj.size() - 1) m_air = 0;
          end else if (m_pend) begin
            m_air = 1; m_k = 0; m_h = traj[0]; m_pend = 0;
          end
        end
      end
      if (je && !air0 && !m_air) m_pend = 1;
    end
    m_ps = s;
    m_pj = j;
  endfunction

  task automatic compare();
    chk("status", game_status, 32'(m_st == 1));
    chk("over", game_over, 32'(m_st == 2));
    chk("tick", frame_tick, 32'(m_st == 1 && m_n % TD == TD - 1));
    chk("height", dinosaur_height, m_h);
    chk("score", score, to_bcd(score_int()));
`ifdef GAME_CTRL_HIGH_SCORE_EN
    chk("high", high_score, to_bcd(m_hs));
`endif
  endtask

  task automatic cyc(bit s, bit j, bit near, int oh);
    button_start    = s;
    button_jump     = j;
    obstacle_near   = near;
    obstacle_height = 6'(oh);
    model_step(s, j, near, oh);
    @(negedge CLK);
    compare();
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_status"}, game_status, 0);
    chk({nm, "_over"}, game_over, 0);
    chk({nm, "_tick"}, frame_tick, 0);
    chk({nm, "_height"}, dinosaur_height, 0);
    chk({nm, "_score"}, score, 0);
  endtask

  task automatic do_reset(string nm);
    RST_N = 1'b0;
    #1;
    chk_zero(nm);
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
  endtask

  initial begin
    int exp_h[6] = '{2, 4, 6, 4, 2, 0};
    int obs_h[6];
    int nt;
    int v;
    bit ft;
    RST_N = 1'b0;
    button_start = 0; button_jump = 0;
    obstacle_near = 0; obstacle_height = 0;
    b_clr = 0; b_en = 0;
    build_traj();
    chk("traj_len", traj.size(), 6);
    do_reset("por");

    cyc(1, 0, 0, 0);
    chk("start_run", game_status, 1);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0, 0, 0);
      chk("tick_pattern", frame_tick, 32'(i % 4 == 3));
    end
    chk("score_two_ticks", score, 16'h0001);

    cyc(0, 1, 0, 0);
    nt = 0;
    for (int i = 0; i < 24; i++) begin
      ft = frame_tick;
      cyc(0, i == 6, 0, 0);
      if (ft && nt < 6) begin
        obs_h[nt] = dinosaur_height;
        nt++;
      end
    end
    chk("jump_ticks", nt, 6);
    for (int i = 0; i < 6; i++) chk("jump_arc", obs_h[i], exp_h[i]);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 0);
      chk("no_double_jump", dinosaur_height, 0);
    end

    for (int i = 0; i < 8 && !game_over; i++) cyc(0, 0, 1, 3);
    chk("collide", game_over, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1'($urandom % 2), 0);
      chk("tick_stopped", frame_tick, 0);
      chk("score_frozen", score, 16'h0005);
    end

    cyc(1, 1, 0, 0);
    chk("restart_score", score, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(i == 3, 0, 0, 0);
      chk("start_eats_jump", dinosaur_height, 0);
      chk("start_ignored", game_status, 1);
    end

`ifdef GAME_CTRL_HIGH_SCORE_EN
    for (int i = 0; i < 200 && score_int() < 12; i++) cyc(0, 0, 0, 0);
    for (int i = 0; i < 8 && !game_over; i++) cyc(0, 0, 1, 63);
    chk("hs_set", high_score, 16'h0012);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 200 && score_int() < 5; i++) cyc(0, 0, 0, 0);
    for (int i = 0; i < 8 && !game_over; i++) cyc(0, 0, 1, 63);
    chk("hs_kept", high_score, 16'h0012);
`endif

    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 12 && m_h == 0; i++) cyc(0, 0, 0, 0);
    chk("mid_ascent", dinosaur_height, 2);
    do_reset("mid_reset");

    for (int i = 0; i < 3000; i++)
      cyc(1'($urandom % 50 == 0), 1'($urandom % 5 == 0),
          1'($urandom % 12 == 0), int'($urandom % 8));

    b_clr = 1; b_en = 1;
    @(negedge CLK);
    chk("bcd_clear", b_cnt, 0);
    v = 0;
    b_clr = 0;
    for (int i = 0; i < 12000; i++) begin
      b_en = 1'($urandom % 16 != 0);
      if (b_en && v < 9999) v++;
      @(negedge CLK);
      chk("bcd_count", b_cnt, to_bcd(v));
    end
    b_en = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("bcd_saturate", b_cnt, 16'h9999);
    end
    b_clr = 1;
    @(negedge CLK);
    chk("bcd_clr_wins", b_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 250000, clock cycles per frame tick; legal values are 2 or more.
REQ-002 Parameter JUMP_STEP, default 2, height change per frame tick while airborne.
REQ-003 Parameter JUMP_MAX, default 40, apex height; legal range is 1..63.
REQ-004 Parameter SCORE_DIV, default 8, frame ticks per score increment.
REQ-005 CLK  in  1  sole clock; all logic is on the rising edge.
REQ-006 RST_N  in  1  reset; asynchronous assert, active-low.
REQ-007 button_start  in  1  start/restart request; level, pre-synchronised.
REQ-008 button_jump  in  1  jump request; level, pre-synchronised.
REQ-009 obstacle_near  in  1  obstacle occupies the dinosaur column.
REQ-010 obstacle_height  in  6  height of that obstacle.
REQ-011 game_status  out  1  high while in RUNNING.
REQ-012 game_over  out  1  high while in GAME_OVER.
REQ-013 frame_tick  out  1  one-cycle pulse per frame, asserted only in RUNNING.
REQ-014 dinosaur_height  out  6  current height; 0 means on the ground.
REQ-015 score  out  16  four BCD digits.

Function
REQ-016 Top FSM: IDLE, RUNNING, GAME_OVER; each button is rising-edge detected against its value in the previous cycle.
REQ-017 IDLE or GAME_OVER + start edge -> RUNNING next cycle; on entry: score=0, height=0, jump FSM=GROUND, tick counter=0.
REQ-018 RUNNING: tick counter counts 0..TICK_DIV-1 then wraps; frame_tick=1 exactly in the cycle the count equals TICK_DIV-1.
REQ-019 Tick counter and frame_tick hold at 0 outside RUNNING.
REQ-020 Jump FSM: GROUND, ASCEND, DESCEND; a jump edge in GROUND sets a pending flag; the next frame_tick moves GROUND -> ASCEND and adds JUMP_STEP.
REQ-021 ASCEND, on each frame_tick: height=min(height+JUMP_STEP, JUMP_MAX); on reaching JUMP_MAX -> DESCEND.
REQ-022 DESCEND, on each frame_tick: height=max(height-JUMP_STEP, 0); on reaching 0 -> GROUND.
REQ-023 Jump edges while in ASCEND or DESCEND are discarded (no double jump, no queueing).
REQ-024 Collision is evaluated on frame_tick using the pre-update height: obstacle_near && height < obstacle_height -> GAME_OVER next cycle.
REQ-025 Score advances by 1 BCD count every SCORE_DIV frame ticks and saturates at 9999.
REQ-026 Collision and score increment on the same tick: collision wins; score, height and jump FSM hold their values.
REQ-027 Start and jump edges in the same cycle in IDLE/GAME_OVER: start is taken; jump is discarded.
REQ-028 In GAME_OVER, score and dinosaur_height freeze at their last values.
REQ-029 Start edges in RUNNING are ignored.

Reset
REQ-030 RST_N low forces IDLE immediately: all outputs 0, counters 0, pending jump cleared, edge-detect registers 0; this holds for reset mid-jump or mid-frame.
REQ-031 Release is synchronous to CLK; the first start edge is detectable in the second cycle after release.

Configuration
REQ-032 Macro GAME_CTRL_HIGH_SCORE_EN defined: adds port high_score out 16 (BCD), updated on entry to GAME_OVER when score > high_score, and cleared only by RST_N.
REQ-033 Macro undefined: no high_score port and no high-score storage; all other behaviour is identical.

Structure
REQ-034 Package game_pkg holds the top FSM and jump FSM state enums, a 4-bit BCD digit type, and parameter defaults.
REQ-035 Sub-module bcd_counter: 4-digit saturating BCD incrementer with enable and clear, used for score.

Verification (TICK_DIV=4, JUMP_STEP=2, JUMP_MAX=6, SCORE_DIV=2)
REQ-036 Reset, then start edge -> game_status=1 one cycle later; frame_tick pulses every 4 cycles.
REQ-037 Jump edge on the ground -> height sequence 2,4,6,4,2,0 across six ticks; a second jump edge during that sequence has no effect.
REQ-038 obstacle_near=1, obstacle_height=3, height=0 at a tick -> game_over=1 next cycle, frame_tick stops, score frozen.
REQ-039 Score preloaded to 9998, 4 more ticks -> score reads 9999 and holds there.
REQ-040 RST_N pulsed low mid-ascent -> all outputs 0 asynchronously, state IDLE; with GAME_CTRL_HIGH_SCORE_EN, a score of 0012 at game over -> high_score=0012, and a later game over at 0005 leaves it at 0012.
